// File: rtl/mem_bus_arbiter.sv
// N-master byte-wide memory bus arbiter with RAM / memory-mapped I/O decode.
// Grant and slave strobes are combinational; read data returns one cycle later.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int IO_SEL_WIDTH   = 3,
    parameter int RR_MODE        = 1
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [NUM_MASTERS-1:0]      m_req,
    input  logic [NUM_MASTERS-1:0]      m_lock,
    input  logic [32*NUM_MASTERS-1:0]   m_a,
    input  logic [NUM_MASTERS-1:0]      m_wr,
    input  logic [8*NUM_MASTERS-1:0]    m_dout,
    output logic [NUM_MASTERS-1:0]      m_gnt,
    output logic [NUM_MASTERS-1:0]      m_rvalid,
    output logic [7:0]                  m_din,
    output logic                        ram_en,
    output logic [RAM_ADDR_WIDTH-1:0]   ram_a,
    output logic                        ram_wr,
    output logic [7:0]                  ram_din,
    input  logic [7:0]                  ram_dout,
    output logic                        io_en,
    output logic [IO_SEL_WIDTH-1:0]     io_sel,
    output logic                        io_wr,
    output logic [7:0]                  io_din,
    input  logic [7:0]                  io_dout,
    input  logic                        io_full
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    logic [NUM_MASTERS-1:0]    is_io;
    logic [NUM_MASTERS-1:0]    elig;
    logic [IDX_W-1:0]          rr_ptr;
    logic [IDX_W-1:0]          owner;
    logic                      owner_vld;
    logic                      owner_ok;
    logic                      locked;
    logic                      gnt_any;
    logic [IDX_W-1:0]          gnt_idx;
    logic [RAM_ADDR_WIDTH-1:0] sel_a;
    logic [7:0]                sel_d;
    logic                      sel_wr;
    logic                      sel_io;
    logic                      rd_vld;
    logic                      rd_io;
    logic                      unused_addr;

    // I/O writes stall while the I/O write buffer is full; I/O reads never do.
    always_comb begin
        is_io       = '0;
        elig        = '0;
        unused_addr = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            is_io[i]    = m_a[32*i+RAM_ADDR_WIDTH] & m_a[32*i+RAM_ADDR_WIDTH-1];
            elig[i]     = m_req[i] & ~(is_io[i] & m_wr[i] & io_full);
            unused_addr = unused_addr ^ (^m_a[32*i+RAM_ADDR_WIDTH+1 +: 31-RAM_ADDR_WIDTH]);
        end
    end

    always_comb begin
        owner_ok = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner == IDX_W'(i)) owner_ok = elig[i] & m_lock[i];
        end
    end

    assign locked = owner_vld & owner_ok;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (locked) begin
            gnt_any = 1'b1;
            gnt_idx = owner;
        end else if (RR_MODE == 0) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!gnt_any && elig[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
        end else begin
            // Two passes: indices at/above the pointer first, then the wrapped ones.
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!gnt_any && elig[i] && (IDX_W'(i) >= rr_ptr)) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!gnt_any && elig[i] && (IDX_W'(i) < rr_ptr)) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        m_gnt  = '0;
        sel_a  = '0;
        sel_d  = '0;
        sel_wr = 1'b0;
        sel_io = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_any && (gnt_idx == IDX_W'(i))) begin
                m_gnt[i] = 1'b1;
                sel_a    = m_a[32*i +: RAM_ADDR_WIDTH];
                sel_d    = m_dout[8*i +: 8];
                sel_wr   = m_wr[i];
                sel_io   = is_io[i];
            end
        end
    end

    always_comb begin
        ram_en  = 1'b0;
        ram_a   = '0;
        ram_wr  = 1'b0;
        ram_din = '0;
        io_en   = 1'b0;
        io_sel  = '0;
        io_wr   = 1'b0;
        io_din  = '0;
        if (gnt_any) begin
            if (sel_io) begin
                io_en  = 1'b1;
                io_sel = sel_a[IO_SEL_WIDTH-1:0];
                io_wr  = sel_wr;
                io_din = sel_d;
            end else begin
                ram_en  = 1'b1;
                ram_a   = sel_a;
                ram_wr  = sel_wr;
                ram_din = sel_d;
            end
        end
    end

    // Locked grants leave the round-robin pointer where it was.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr    <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            rd_vld    <= 1'b0;
            rd_io     <= 1'b0;
        end else begin
            owner_vld <= gnt_any;
            rd_vld    <= gnt_any & ~sel_wr;
            if (gnt_any) begin
                owner <= gnt_idx;
                rd_io <= sel_io;
            end
            if (gnt_any && !locked) begin
                rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_comb begin
        m_rvalid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_rvalid[i] = rd_vld & (owner == IDX_W'(i));
        end
    end

    assign m_din = rd_vld ? (rd_io ? io_dout : ram_dout) : 8'h00;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, lock, wr;
    logic [31:0] a0, a1;
    logic [7:0]  d0, d1;
    logic [7:0]  ram_dout, io_dout;
    logic        io_full;

    logic [1:0]  gnt, rvalid, fp_gnt, fp_rvalid;
    logic [7:0]  din, fp_din;
    logic        ram_en, ram_wr, io_en, io_wr;
    logic        fp_ram_en, fp_ram_wr, fp_io_en, fp_io_wr;
    logic [16:0] ram_a, fp_ram_a;
    logic [7:0]  ram_din, io_din, fp_ram_din, fp_io_din;
    logic [2:0]  io_sel, fp_io_sel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.NUM_MASTERS(2), .RAM_ADDR_WIDTH(17), .IO_SEL_WIDTH(3), .RR_MODE(1)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .m_req(req), .m_lock(lock), .m_a({a1, a0}),
        .m_wr(wr), .m_dout({d1, d0}), .m_gnt(gnt), .m_rvalid(rvalid), .m_din(din),
        .ram_en(ram_en), .ram_a(ram_a), .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout),
        .io_en(io_en), .io_sel(io_sel), .io_wr(io_wr), .io_din(io_din), .io_dout(io_dout),
        .io_full(io_full)
    );

    mem_bus_arbiter #(.NUM_MASTERS(2), .RAM_ADDR_WIDTH(17), .IO_SEL_WIDTH(3), .RR_MODE(0)) dut_fp (
        .clk_in(clk), .rst_n_in(rst_n), .m_req(req), .m_lock(lock), .m_a({a1, a0}),
        .m_wr(wr), .m_dout({d1, d0}), .m_gnt(fp_gnt), .m_rvalid(fp_rvalid), .m_din(fp_din),
        .ram_en(fp_ram_en), .ram_a(fp_ram_a), .ram_wr(fp_ram_wr), .ram_din(fp_ram_din),
        .ram_dout(ram_dout), .io_en(fp_io_en), .io_sel(fp_io_sel), .io_wr(fp_io_wr),
        .io_din(fp_io_din), .io_dout(io_dout), .io_full(io_full)
    );

    typedef struct {
        logic [1:0]  req, lock, wr;
        logic [31:0] a0, a1;
        logic [7:0]  d0, d1;
        logic        full;
        logic [7:0]  rd, iod;
        logic [1:0]  gnt, gnt_fp;
        logic        ram_en, io_en;
        logic [16:0] ram_a;
        logic        ram_wr;
        logic [7:0]  ram_din;
        logic [2:0]  io_sel;
        logic        io_wr;
        logic [7:0]  io_din;
        logic [1:0]  rvalid;
        logic [7:0]  din;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                         input logic [31:0] x0, input logic [31:0] x1,
                         input logic [7:0] y0, input logic [7:0] y1, input logic f,
                         input logic [7:0] rdd, input logic [7:0] iodd);
        req = r; lock = l; wr = w; a0 = x0; a1 = x1; d0 = y0; d1 = y1;
        io_full = f; ram_dout = rdd; io_dout = iodd;
    endtask

    initial begin
        //          req    lock   wr     a0            a1            d0     d1     full  rd     iod    gnt    gnt_fp ram io  ram_a      rwr rdin   sel   iwr idin   rvalid din
        tbl[0]  = '{2'b11, 2'b00, 2'b00, 32'h00010,    32'h00020,    8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 2'b01, 2'b01, 1'b1, 1'b0, 17'h00010, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 2'b00, 8'h00};
        tbl[1]  = '{2'b11, 2'b00, 2'b00, 32'h00010,    32'h00020,    8'h00, 8'h00, 1'b0, 8'hA0, 8'h00, 2'b10, 2'b01, 1'b1, 1'b0, 17'h00020, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 2'b01, 8'hA0};
        tbl[2]  = '{2'b11, 2'b00, 2'b00, 32'h00010,    32'h00020,    8'h00, 8'h00, 1'b0, 8'hB1, 8'h00, 2'b01, 2'b01, 1'b1, 1'b0, 17'h00010, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 2'b10, 8'hB1};
        tbl[3]  = '{2'b11, 2'b00, 2'b00, 32'h00010,    32'h00020,    8'h00, 8'h00, 1'b0, 8'hA2, 8'h00, 2'b10, 2'b01, 1'b1, 1'b0, 17'h00020, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 2'b01, 8'hA2};
        tbl[4]  = '{2'b10, 2'b00, 2'b00, 32'h00010,    32'h30000,    8'h00, 8'h00, 1'b0, 8'hB3, 8'h00, 2'b10, 2'b10, 1'b0, 1'b1, 17'h00000, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 2'b10, 8'hB3};
        tbl[5]  = '{2'b10, 2'b00, 2'b00, 32'h00010,    32'h00004,    8'h00, 8'h00, 1'b0, 8'h99, 8'h41, 2'b10, 2'b10, 1'b1, 1'b0, 17'h00004, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 2'b10, 8'h41};
        tbl[6]  = '{2'b11, 2'b00, 2'b01, 32'h30004,    32'hFF000123, 8'h55, 8'h00, 1'b1, 8'h77, 8'h00, 2'b10, 2'b10, 1'b1, 1'b0, 17'h00123, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 2'b10, 8'h77};
        tbl[7]  = '{2'b01, 2'b00, 2'b01, 32'h30004,    32'hFF000123, 8'h55, 8'h00, 1'b0, 8'h12, 8'h00, 2'b01, 2'b01, 1'b0, 1'b1, 17'h00000, 1'b0, 8'h00, 3'd4, 1'b1, 8'h55, 2'b10, 8'h12};
        tbl[8]  = '{2'b00, 2'b00, 2'b00, 32'h00000,    32'h00000,    8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 17'h00000, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 2'b00, 8'h00};
        tbl[9]  = '{2'b01, 2'b00, 2'b00, 32'h30003,    32'h00000,    8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 2'b01, 2'b01, 1'b0, 1'b1, 17'h00000, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 2'b00, 8'h00};
        tbl[10] = '{2'b10, 2'b00, 2'b10, 32'h00000,    32'h00050,    8'h00, 8'h3C, 1'b1, 8'h00, 8'h5A, 2'b10, 2'b10, 1'b1, 1'b0, 17'h00050, 1'b1, 8'h3C, 3'd0, 1'b0, 8'h00, 2'b01, 8'h5A};
        tbl[11] = '{2'b11, 2'b00, 2'b00, 32'h00010,    32'h00020,    8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 2'b01, 2'b01, 1'b1, 1'b0, 17'h00010, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 2'b00, 8'h00};
        tbl[12] = '{2'b00, 2'b00, 2'b00, 32'h00010,    32'h00020,    8'h00, 8'h00, 1'b0, 8'h6B, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 17'h00000, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 2'b01, 8'h6B};

        // Reset state, with a request present to show grants stay combinational.
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0, 1'b0, 8'h0, 8'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst rvalid", 32'(rvalid), 32'h0);
        chk("rst din", 32'(din), 32'h0);
        chk("rst ram_en", 32'(ram_en), 32'h0);
        chk("rst io_en", 32'(io_en), 32'h0);
        chk("rst gnt idle", 32'(gnt), 32'h0);
        req = 2'b01; a0 = 32'h00010;
        #1;
        chk("rst gnt comb", 32'(gnt), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted between a read grant and its return edge drops the read.
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 32'h00010, 32'h0, 8'h0, 8'h0, 1'b0, 8'h0, 8'h0);
        #1;
        chk("midrd gnt", 32'(gnt), 32'h1);
        chk("midrd ram_a", 32'(ram_a), 32'h10);
        #1 rst_n = 1'b0;
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0, 1'b0, 8'hEE, 8'h0);
        #1;
        chk("midrd rvalid", 32'(rvalid), 32'h0);
        chk("midrd din", 32'(din), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b00, 32'h00010, 32'h00020, 8'h0, 8'h0, 1'b0, 8'h0, 8'h0);
        #1;
        chk("post-rst rr gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        drive(2'b10, 2'b00, 2'b00, 32'h00010, 32'h00020, 8'h0, 8'h0, 1'b0, 8'h5D, 8'h0);
        #1;
        chk("post-rst gnt1", 32'(gnt), 32'h2);
        chk("post-rst rvalid", 32'(rvalid), 32'h1);
        chk("post-rst din", 32'(din), 32'h5D);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0, 1'b0, 8'h6E, 8'h0);
        #1;
        chk("drop rvalid", 32'(rvalid), 32'h2);
        chk("drop din", 32'(din), 32'h6E);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i].req, tbl[i].lock, tbl[i].wr, tbl[i].a0, tbl[i].a1,
                  tbl[i].d0, tbl[i].d1, tbl[i].full, tbl[i].rd, tbl[i].iod);
            #1;
            chk($sformatf("r%0d gnt", i),     32'(gnt),     32'(tbl[i].gnt));
            chk($sformatf("r%0d fp_gnt", i),  32'(fp_gnt),  32'(tbl[i].gnt_fp));
            chk($sformatf("r%0d ram_en", i),  32'(ram_en),  32'(tbl[i].ram_en));
            chk($sformatf("r%0d io_en", i),   32'(io_en),   32'(tbl[i].io_en));
            chk($sformatf("r%0d ram_a", i),   32'(ram_a),   32'(tbl[i].ram_a));
            chk($sformatf("r%0d ram_wr", i),  32'(ram_wr),  32'(tbl[i].ram_wr));
            chk($sformatf("r%0d ram_din", i), 32'(ram_din), 32'(tbl[i].ram_din));
            chk($sformatf("r%0d io_sel", i),  32'(io_sel),  32'(tbl[i].io_sel));
            chk($sformatf("r%0d io_wr", i),   32'(io_wr),   32'(tbl[i].io_wr));
            chk($sformatf("r%0d io_din", i),  32'(io_din),  32'(tbl[i].io_din));
            chk($sformatf("r%0d rvalid", i),  32'(rvalid),  32'(tbl[i].rvalid));
            chk($sformatf("r%0d din", i),     32'(din),     32'(tbl[i].din));
        end

        // Lock burst: master 1 holds the bus for 5 cycles against master 0.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive((k == 0) ? 2'b10 : 2'b11, 2'b10, 2'b00, 32'h00010, 32'h00020,
                  8'h0, 8'h0, 1'b0, 8'hC0 + 8'(k), 8'h0);
            #1;
            chk($sformatf("lock%0d gnt", k), 32'(gnt), 32'h2);
            chk($sformatf("lock%0d fp_gnt", k), 32'(fp_gnt), 32'h2);
            if (k > 0) begin
                chk($sformatf("lock%0d rvalid", k), 32'(rvalid), 32'h2);
                chk($sformatf("lock%0d din", k), 32'(din), 32'hC0 + 32'(k));
            end
        end
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b00, 32'h00010, 32'h00020, 8'h0, 8'h0, 1'b0, 8'h0, 8'h0);
        #1;
        chk("unlock gnt", 32'(gnt), 32'h1);
        chk("unlock fp_gnt", 32'(fp_gnt), 32'h1);

        // A locked I/O writer loses the bus once io_full rises.
        @(negedge clk);
        drive(2'b10, 2'b10, 2'b10, 32'h00010, 32'h30001, 8'h0, 8'h9A, 1'b0, 8'h0, 8'h0);
        #1;
        chk("lkio gnt", 32'(gnt), 32'h2);
        chk("lkio io_wr", 32'(io_wr), 32'h1);
        chk("lkio io_sel", 32'(io_sel), 32'h1);
        @(negedge clk);
        drive(2'b11, 2'b10, 2'b10, 32'h00010, 32'h30001, 8'h0, 8'h9A, 1'b1, 8'h0, 8'h0);
        #1;
        chk("lkfull gnt", 32'(gnt), 32'h1);
        chk("lkfull fp_gnt", 32'(fp_gnt), 32'h1);
        chk("lkfull io_en", 32'(io_en), 32'h0);
        chk("lkfull ram_en", 32'(ram_en), 32'h1);

        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h0, 8'h0, 1'b0, 8'h0, 8'h0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised N-master, byte-wide system memory bus arbiter and address decoder sitting between bus masters (CPU, HCI debug port, future DMA) and the shared RAM / memory-mapped I/O. Each cycle it grants at most one master, decodes its address into the RAM or I/O region, drives the slave strobes, and returns read data one cycle later with a registered source select. It provides fixed-priority or round-robin arbitration, bus locking for debug bursts, and I/O-full back-pressure.

## Interface
- NUM_MASTERS, 2: number of masters (1..8); master 0 is highest fixed priority.
- RAM_ADDR_WIDTH, 17: RAM address width; bits [RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11 select I/O.
- IO_SEL_WIDTH, 3: I/O register select width, taken from a[IO_SEL_WIDTH-1:0].
- RR_MODE, 1: 0 = fixed priority, 1 = round-robin.
- clk_in  input  1  system clock; all state on rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- m_req  input  NUM_MASTERS  per-master access request.
- m_lock  input  NUM_MASTERS  per-master lock: keep grant while held and requesting.
- m_a  input  32*NUM_MASTERS  flattened addresses, master i at [32i+31:32i].
- m_wr  input  NUM_MASTERS  1 = write, 0 = read.
- m_dout  input  8*NUM_MASTERS  flattened write data.
- m_gnt  output  NUM_MASTERS  one-hot (or zero) grant, combinational.
- m_rvalid  output  NUM_MASTERS  registered: read data for master i valid on m_din.
- m_din  output  8  read data, shared by all masters.
- ram_en  output  1  RAM access strobe.
- ram_a  output  RAM_ADDR_WIDTH  RAM address.
- ram_wr  output  1  RAM write.
- ram_din  output  8  RAM write data.
- ram_dout  input  8  RAM read data, valid one cycle after access.
- io_en  output  1  I/O access strobe.
- io_sel  output  IO_SEL_WIDTH  I/O register select.
- io_wr  output  1  I/O write.
- io_din  output  8  I/O write data.
- io_dout  input  8  I/O read data, valid one cycle after access.
- io_full  input  1  I/O write buffer full.

## Operation
- Eligibility: master i eligible iff m_req[i] and not (address in I/O region and m_wr[i] and io_full). I/O reads are never blocked.
- Lock: if last-cycle owner (registered, valid flag) still has m_req and m_lock set and is eligible, it is granted regardless of mode.
- Else RR_MODE=0: lowest-index eligible master wins. RR_MODE=1: first eligible master searching from rr_ptr upward, wrapping at NUM_MASTERS-1 → 0.
- rr_ptr updates to (granted index + 1) mod NUM_MASTERS on each grant; unchanged when no grant; unchanged during locked grants.
- Granted master's access issues same cycle: region I/O → io_en=1, io_sel, io_wr, io_din; else ram_en=1, ram_a=a[RAM_ADDR_WIDTH-1:0], ram_wr, ram_din. Exactly one of ram_en/io_en high per grant; both 0 with no grant.
- No grant: ram_wr=io_wr=0; address/data outputs 0.
- Read issued at cycle t: register owner index and q_io flag; at t+1 m_rvalid[owner]=1 and m_din = q_io ? io_dout : ram_dout. Writes never raise m_rvalid.
- Masters needing data hold their request until granted; a grant consumes exactly one access.

## Timing
- Reset (rst_n_in low, any time): rr_ptr=0, owner valid=0, m_rvalid=0, m_din=0; combinational outputs follow inputs but read-return state is cleared, so an in-flight read is dropped with no m_rvalid.
- Grant-to-strobe latency 0; read latency 1 cycle; throughput one access per cycle, back-to-back reads from different masters allowed (m_rvalid changes owner each cycle).
- io_full rising while an I/O write is requested: that master receives no grant; other eligible masters may be granted that cycle; lock does not override io_full.
- Request dropped after grant-cycle read: m_rvalid still asserted next cycle.
- NUM_MASTERS=1: m_gnt = eligibility of master 0; rr_ptr stays 0.

## Test plan
- Reset mid-read: master 0 reads 0x00010, assert rst_n_in low before next edge -> m_rvalid stays 0; after release rr_ptr=0.
- RR contention: RR_MODE=1, both masters request reads 4 cycles -> m_gnt 01,10,01,10; m_rvalid follows one cycle later with RAM bytes.
- Fixed priority: RR_MODE=0, both request 3 cycles -> m_gnt 01 every cycle; master 1 granted only after m_req[0] drops.
- I/O decode: master 1 reads 0x30000 (io_sel=0), io_dout=0x41 -> io_en=1, ram_en=0, next cycle m_din=0x41, m_rvalid=10; read 0x00004 -> ram_en=1, ram_a=0x00004.
- Back-pressure: io_full=1, master 0 writes 0x30004 data 0x55, master 1 reads RAM -> master 1 granted, io_en=0; io_full=0 -> master 0 granted, io_wr=1, io_sel=4, io_din=0x55.
- Lock burst: master 1 granted with m_lock=1 for 5 cycles while master 0 requests -> m_gnt=10 all 5 cycles; lock released -> master 0 granted next cycle.
